// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared types and defaults for the MEM-stage controller.
//   state_e        : bus FSM states (IDLE, BUSY)
//   DATA_W_DEF     : default data/address width
//   REG_W_DEF      : default destination register index width
//   ACK_TIMEOUT_DEF: default BUSY cycles allowed before abort
//   cnt_width()    : width of the BUSY-cycle timeout counter
package mem_stage_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  localparam int DATA_W_DEF      = 32;
  localparam int REG_W_DEF       = 5;
  localparam int ACK_TIMEOUT_DEF = 16;

  // The counter only has to reach ACK_TIMEOUT-1.
  function automatic int cnt_width(input int timeout);
    return $clog2(timeout);
  endfunction

endpackage

// File: rtl/mem_wb_reg.sv
// mem_wb_reg: MEM/WB pipeline register.
//   clk, rst_n      : clock, synchronous active-low reset
//   load            : 1 = capture the *_d inputs, 0 = insert a bubble
//   *_d             : next-entry controls and data
//   *_q             : registered MEM/WB entry
// A bubble clears only the write-back controls; data fields hold their value.
module mem_wb_reg
  import mem_stage_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_W  = REG_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              reg_write_d,
  input  logic              mem_to_reg_d,
  input  logic [DATA_W-1:0] read_data_d,
  input  logic [DATA_W-1:0] alu_d,
  input  logic [REG_W-1:0]  dest_d,
  output logic              reg_write_q,
  output logic              mem_to_reg_q,
  output logic [DATA_W-1:0] read_data_q,
  output logic [DATA_W-1:0] alu_q,
  output logic [REG_W-1:0]  dest_q
);

  // MEM/WB entry: load a new entry or bubble the controls
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      reg_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      read_data_q  <= '0;
      alu_q        <= '0;
      dest_q       <= '0;
    end else if (load) begin
      reg_write_q  <= reg_write_d;
      mem_to_reg_q <= mem_to_reg_d;
      read_data_q  <= read_data_d;
      alu_q        <= alu_d;
      dest_q       <= dest_d;
    end else begin
      reg_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
    end
  end

endmodule

// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: MEM-stage controller behind the EX/MEM register.
//   Inputs : EX/MEM controls (BranchIN, MemReadIN, MemtoRegIN, MemWriteIN,
//            RegWriteIN, zeroIN), ALUsaltoIN, ALU_IN, readData2IN, DestinoIN,
//            memory bus mem_ack_i / mem_rdata_i.
//   Outputs: pcsrc_o / branch_target_o (branch resolve), stall_o (pipeline
//            freeze), mem_req_o / mem_we_o / mem_addr_o / mem_wdata_o (bus),
//            bus_err_o (timeout pulse), align_err_o (misalignment pulse),
//            MEM/WB entry RegWriteOUT, MemtoRegOUT, readDataOUT, ALU_OUT,
//            DestinoOUT.
// Optional feature macro: MEM_ALIGN_CHECK_EN. When defined, a misaligned
// access is rejected (no request, no stall, align_err_o pulse). When
// undefined, align_err_o is 0 and the address low bits are forced to 00.
module mem_stage_ctrl
  import mem_stage_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int REG_W       = REG_W_DEF,
  parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              BranchIN,
  input  logic              MemReadIN,
  input  logic              MemtoRegIN,
  input  logic              MemWriteIN,
  input  logic              RegWriteIN,
  input  logic              zeroIN,
  input  logic [DATA_W-1:0] ALUsaltoIN,
  input  logic [DATA_W-1:0] ALU_IN,
  input  logic [DATA_W-1:0] readData2IN,
  input  logic [REG_W-1:0]  DestinoIN,
  output logic              pcsrc_o,
  output logic [DATA_W-1:0] branch_target_o,
  output logic              stall_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [DATA_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              bus_err_o,
  output logic              align_err_o,
  output logic              RegWriteOUT,
  output logic              MemtoRegOUT,
  output logic [DATA_W-1:0] readDataOUT,
  output logic [DATA_W-1:0] ALU_OUT,
  output logic [REG_W-1:0]  DestinoOUT
);

  localparam int              CNT_W    = cnt_width(ACK_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

  state_e             state_r;
  logic [CNT_W-1:0]   cnt_r;
  logic               req_r;
  logic               we_r;
  logic [DATA_W-1:0]  addr_r;
  logic [DATA_W-1:0]  wdata_r;
  logic               bus_err_r;

  logic               access_s;
  logic               misalign_s;
  logic               issue_s;
  logic               ack_s;
  logic               timeout_s;
  logic               align_fault_s;
  logic               stall_s;
  logic               load_s;
  logic [DATA_W-1:0]  issue_addr_s;

  // Access decode, stall and MEM/WB load qualification
  always_comb begin
    access_s = MemReadIN | MemWriteIN;
`ifdef MEM_ALIGN_CHECK_EN
    misalign_s   = access_s & (ALU_IN[1:0] != 2'b00);
    issue_addr_s = ALU_IN;
`else
    misalign_s   = 1'b0;
    issue_addr_s = {ALU_IN[DATA_W-1:2], 2'b00};
`endif
    issue_s       = (state_r == IDLE) & access_s & ~misalign_s;
    align_fault_s = (state_r == IDLE) & misalign_s;
    ack_s         = (state_r == BUSY) & mem_ack_i;
    // Ack on the terminal count wins over the abort.
    timeout_s     = (state_r == BUSY) & ~mem_ack_i & (cnt_r == CNT_LAST);
    stall_s       = issue_s | ((state_r == BUSY) & ~mem_ack_i & ~timeout_s);
    // Timeout and alignment faults must not retire the instruction.
    load_s        = ~stall_s & ~timeout_s & ~align_fault_s;
  end

  // Bus FSM: issue, wait for ack or timeout, report abort
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      cnt_r     <= '0;
      req_r     <= 1'b0;
      we_r      <= 1'b0;
      addr_r    <= '0;
      wdata_r   <= '0;
      bus_err_r <= 1'b0;
    end else begin
      bus_err_r <= timeout_s;
      case (state_r)
        IDLE: begin
          if (issue_s) begin
            addr_r  <= issue_addr_s;
            wdata_r <= readData2IN;
            we_r    <= MemWriteIN;
            req_r   <= 1'b1;
            cnt_r   <= '0;
            state_r <= BUSY;
          end else begin
            req_r   <= 1'b0;
            state_r <= IDLE;
          end
        end
        BUSY: begin
          if (ack_s || timeout_s) begin
            req_r   <= 1'b0;
            state_r <= IDLE;
          end else begin
            cnt_r   <= cnt_r + CNT_W'(1);
            state_r <= BUSY;
          end
        end
        default: begin
          req_r   <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

`ifdef MEM_ALIGN_CHECK_EN
  logic align_err_r;

  // One-cycle misalignment pulse
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      align_err_r <= 1'b0;
    end else begin
      align_err_r <= align_fault_s;
    end
  end

  assign align_err_o = align_err_r;
`else
  assign align_err_o = 1'b0;
`endif

  assign stall_o         = stall_s;
  assign pcsrc_o         = BranchIN & zeroIN & ~stall_s;
  assign branch_target_o = ALUsaltoIN;
  assign mem_req_o       = req_r;
  assign mem_we_o        = we_r;
  assign mem_addr_o      = addr_r;
  assign mem_wdata_o     = wdata_r;
  assign bus_err_o       = bus_err_r;

  mem_wb_reg #(
    .DATA_W (DATA_W),
    .REG_W  (REG_W)
  ) u_mem_wb (
    .clk          (clk),
    .rst_n        (rst_n),
    .load         (load_s),
    .reg_write_d  (RegWriteIN),
    .mem_to_reg_d (MemtoRegIN),
    .read_data_d  (mem_rdata_i),
    .alu_d        (ALU_IN),
    .dest_d       (DestinoIN),
    .reg_write_q  (RegWriteOUT),
    .mem_to_reg_q (MemtoRegOUT),
    .read_data_q  (readDataOUT),
    .alu_q        (ALU_OUT),
    .dest_q       (DestinoOUT)
  );

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb_mem_stage_ctrl: randomized scoreboard bench for mem_stage_ctrl.
// The stimulus side walks each instruction through its memory transaction
// at instruction level and pushes, per cycle, the expected combinational
// outputs plus the expected registered state; a monitor pops and compares
// at every falling edge.
module tb_mem_stage_ctrl;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;
  localparam int T      = 16;
`ifdef MEM_ALIGN_CHECK_EN
  localparam bit ALIGN_CHK = 1'b1;
`else
  localparam bit ALIGN_CHK = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic              BranchIN, MemReadIN, MemtoRegIN, MemWriteIN, RegWriteIN, zeroIN;
  logic [DATA_W-1:0] ALUsaltoIN, ALU_IN, readData2IN;
  logic [REG_W-1:0]  DestinoIN;
  logic              pcsrc_o, stall_o, mem_req_o, mem_we_o;
  logic [DATA_W-1:0] branch_target_o, mem_addr_o, mem_wdata_o;
  logic              mem_ack_i;
  logic [DATA_W-1:0] mem_rdata_i;
  logic              bus_err_o, align_err_o;
  logic              RegWriteOUT, MemtoRegOUT;
  logic [DATA_W-1:0] readDataOUT, ALU_OUT;
  logic [REG_W-1:0]  DestinoOUT;

  mem_stage_ctrl #(.DATA_W(DATA_W), .REG_W(REG_W), .ACK_TIMEOUT(T)) dut (
    .clk(clk), .rst_n(rst_n),
    .BranchIN(BranchIN), .MemReadIN(MemReadIN), .MemtoRegIN(MemtoRegIN),
    .MemWriteIN(MemWriteIN), .RegWriteIN(RegWriteIN), .zeroIN(zeroIN),
    .ALUsaltoIN(ALUsaltoIN), .ALU_IN(ALU_IN), .readData2IN(readData2IN),
    .DestinoIN(DestinoIN), .pcsrc_o(pcsrc_o), .branch_target_o(branch_target_o),
    .stall_o(stall_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_ack_i(mem_ack_i),
    .mem_rdata_i(mem_rdata_i), .bus_err_o(bus_err_o), .align_err_o(align_err_o),
    .RegWriteOUT(RegWriteOUT), .MemtoRegOUT(MemtoRegOUT), .readDataOUT(readDataOUT),
    .ALU_OUT(ALU_OUT), .DestinoOUT(DestinoOUT)
  );

  typedef struct packed {
    logic              rw;
    logic              m2r;
    logic [DATA_W-1:0] rd;
    logic [DATA_W-1:0] alu;
    logic [REG_W-1:0]  dst;
    logic              req;
    logic              we;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              berr;
    logic              aerr;
  } regs_t;

  typedef struct packed {
    logic              chk;
    logic              stall;
    logic              pcsrc;
    logic [DATA_W-1:0] bt;
    regs_t             r;
  } rec_t;

  rec_t  q[$];
  regs_t cur, nxt;
  int    n_checks = 0;
  int    n_pass   = 0;

  task automatic check(input string name, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Monitor: compare DUT outputs with the scoreboard every falling edge
  initial begin
    rec_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        if (e.chk) begin
          check("stall_o", 32'(stall_o), 32'(e.stall));
          check("pcsrc_o", 32'(pcsrc_o), 32'(e.pcsrc));
          check("branch_target_o", branch_target_o, e.bt);
        end
        check("RegWriteOUT", 32'(RegWriteOUT), 32'(e.r.rw));
        check("MemtoRegOUT", 32'(MemtoRegOUT), 32'(e.r.m2r));
        check("readDataOUT", readDataOUT, e.r.rd);
        check("ALU_OUT", ALU_OUT, e.r.alu);
        check("DestinoOUT", 32'(DestinoOUT), 32'(e.r.dst));
        check("mem_req_o", 32'(mem_req_o), 32'(e.r.req));
        check("mem_we_o", 32'(mem_we_o), 32'(e.r.we));
        check("mem_addr_o", mem_addr_o, e.r.addr);
        check("mem_wdata_o", mem_wdata_o, e.r.wdata);
        check("bus_err_o", 32'(bus_err_o), 32'(e.r.berr));
        check("align_err_o", 32'(align_err_o), 32'(e.r.aerr));
      end
    end
  end

  // Push this cycle's expectations, advance one clock, adopt the predicted state.
  task automatic tick(input logic chk, input logic st, input logic pc);
    rec_t e;
    e.chk = chk; e.stall = st; e.pcsrc = pc; e.bt = ALUsaltoIN; e.r = cur;
    q.push_back(e);
    @(posedge clk); #1;
    cur = nxt;
  endtask

  task automatic start_cycle();
    nxt = cur; nxt.berr = 1'b0; nxt.aerr = 1'b0;
  endtask

  task automatic wb_load();
    nxt.rw = RegWriteIN; nxt.m2r = MemtoRegIN; nxt.rd = mem_rdata_i;
    nxt.alu = ALU_IN; nxt.dst = DestinoIN;
  endtask

  task automatic bubble();
    nxt.rw = 1'b0; nxt.m2r = 1'b0;
  endtask

  // Run the instruction currently on the EX/MEM inputs; the access is
  // acknowledged in BUSY cycle d (d > T means never).
  task automatic run_cur(input int d);
    start_cycle();
    mem_ack_i   = 1'($urandom);
    mem_rdata_i = $urandom;
    if (!(MemReadIN | MemWriteIN)) begin
      wb_load();
      tick(1'b1, 1'b0, BranchIN & zeroIN);
    end else if (ALIGN_CHK && (ALU_IN[1:0] != 2'b00)) begin
      nxt.aerr = 1'b1;
      bubble();
      tick(1'b1, 1'b0, BranchIN & zeroIN);
    end else begin
      bubble();
      nxt.req = 1'b1; nxt.we = MemWriteIN;
      nxt.addr = ALU_IN & ~32'h3; nxt.wdata = readData2IN;
      tick(1'b1, 1'b1, 1'b0);
      for (int j = 1; j <= T; j++) begin
        start_cycle();
        mem_ack_i   = (j == d);
        mem_rdata_i = $urandom;
        if (j == d) begin
          wb_load(); nxt.req = 1'b0;
          tick(1'b1, 1'b0, BranchIN & zeroIN);
          break;
        end else if (j == T) begin
          bubble(); nxt.req = 1'b0; nxt.berr = 1'b1;
          tick(1'b1, 1'b0, BranchIN & zeroIN);
        end else begin
          bubble();
          tick(1'b1, 1'b1, 1'b0);
        end
      end
    end
  endtask

  task automatic set_instr(input logic br, input logic z, input logic rd, input logic wr,
                           input logic rw, input logic m2r, input logic [DATA_W-1:0] tgt,
                           input logic [DATA_W-1:0] alu, input logic [DATA_W-1:0] sd,
                           input logic [REG_W-1:0] dst);
    BranchIN = br; zeroIN = z; MemReadIN = rd; MemWriteIN = wr; RegWriteIN = rw;
    MemtoRegIN = m2r; ALUsaltoIN = tgt; ALU_IN = alu; readData2IN = sd; DestinoIN = dst;
  endtask

  task automatic rand_instr(input int kind);
    set_instr(1'($urandom), 1'($urandom), kind == 1, kind == 2, 1'($urandom),
              1'($urandom), $urandom, $urandom, $urandom, 5'($urandom));
  endtask

  int d_opts[7];

  initial begin
    rst_n = 1'b0;
    set_instr(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h55, 32'h44, 32'h33, 5'd3);
    mem_ack_i = 1'b1; mem_rdata_i = 32'hA5A5A5A5;
    @(posedge clk); #1;
    cur = '0; nxt = '0;
    tick(1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;

    // Directed: load with ack in 3rd BUSY cycle
    set_instr(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0, 32'h40, 32'h0, 5'd5);
    start_cycle(); mem_ack_i = 1'b0;
    bubble(); nxt.req = 1'b1; nxt.we = 1'b0; nxt.addr = 32'h40; nxt.wdata = 32'h0;
    tick(1'b1, 1'b1, 1'b0);
    start_cycle(); bubble(); tick(1'b1, 1'b1, 1'b0);
    start_cycle(); bubble(); tick(1'b1, 1'b1, 1'b0);
    start_cycle(); mem_ack_i = 1'b1; mem_rdata_i = 32'hDEADBEEF;
    nxt.rw = 1'b1; nxt.m2r = 1'b1; nxt.rd = 32'hDEADBEEF; nxt.alu = 32'h40; nxt.dst = 5'd5;
    nxt.req = 1'b0;
    tick(1'b1, 1'b0, 1'b0);

    // Directed: store with immediate ack
    set_instr(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h80, 32'h1234, 5'd7);
    run_cur(1);
    // Directed: branch without access
    set_instr(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h100, 32'h9, 32'h0, 5'd1);
    run_cur(1);
    // Directed: timeout, never acked
    set_instr(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h200, 32'h60, 32'h0, 5'd9);
    run_cur(T + 1);
    // Directed: ack on the terminal count wins
    set_instr(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 32'h64, 32'hCAFE, 5'd2);
    run_cur(T);
    // Directed: misaligned read
    set_instr(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0, 32'h42, 32'h0, 5'd4);
    run_cur(2);

    // Directed: reset mid-BUSY, then a late ack in IDLE
    set_instr(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0, 32'h10, 32'h0, 5'd6);
    start_cycle(); mem_ack_i = 1'b0;
    bubble(); nxt.req = 1'b1; nxt.we = 1'b0; nxt.addr = 32'h10; nxt.wdata = 32'h0;
    tick(1'b1, 1'b1, 1'b0);
    start_cycle(); bubble(); tick(1'b1, 1'b1, 1'b0);
    rst_n = 1'b0; nxt = '0;
    tick(1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    set_instr(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h77, 32'h0, 5'd8);
    start_cycle(); mem_ack_i = 1'b1; mem_rdata_i = 32'h0BAD0BAD;
    wb_load();
    tick(1'b1, 1'b0, 1'b0);
    rand_instr(0); run_cur(1);

    // Random instructions with a spread of ack delays
    d_opts[0] = 1; d_opts[1] = 2; d_opts[2] = 3; d_opts[3] = T - 1;
    d_opts[4] = T; d_opts[5] = T + 1; d_opts[6] = 0;
    for (int n = 0; n < 150; n++) begin
      int k;
      int d;
      k = $urandom_range(0, 2);
      d = d_opts[$urandom_range(0, 6)];
      if (d == 0) d = $urandom_range(1, T);
      rand_instr(k);
      run_cur(d);
    end

    rand_instr(0); run_cur(1);
    repeat (2) @(negedge clk);
    check("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
